// File: rtl/tl_pkg.sv
// tl_pkg: layer states and word width shared by the FIFO/FSM stage and the downstream counter.
package tl_pkg;
    localparam int TL_DATA_W = 12;
    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000,
        ST_ERROR  = 4'b1111
    } tl_state_e;
endpackage

// File: rtl/tl_sync_fifo.sv
// tl_sync_fifo: synchronous FIFO with flush and status flags registered from the next-state count.
module tl_sync_fifo #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              flush,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PTR_W:0]    thr_af,
    input  logic [PTR_W:0]    thr_ae,
    output logic [DATA_W-1:0] rd_data,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count_n;

    always_comb count_n = flush ? '0 : count + (PTR_W+1)'(wr) - (PTR_W+1)'(rd);

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr       <= flush ? '0 : wr_ptr + PTR_W'(wr);
            rd_ptr       <= flush ? '0 : rd_ptr + PTR_W'(rd);
            count        <= count_n;
            full         <= count_n == (PTR_W+1)'(DEPTH);
            empty        <= count_n == '0;
            almost_full  <= count_n >= thr_af;
            almost_empty <= count_n <= thr_ae;
        end
    end

    // Storage carries no reset; contents are don't-care after reset or flush.
    always_ff @(posedge clk)
        if (wr && !flush) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/tl_fifo_fsm.sv
// tl_fifo_fsm: transaction-layer word FIFO plus layer control FSM feeding the change counter.
// Define TL_FIFO_FSM_ERRCNT_EN to add a saturating overflow/underflow event counter (err_count).
module tl_fifo_fsm
    import tl_pkg::*;
#(
    parameter int DATA_W = TL_DATA_W,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              init,
    input  logic [PTR_W:0]    thr_af,
    input  logic [PTR_W:0]    thr_ae,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [3:0]        state,
`ifdef TL_FIFO_FSM_ERRCNT_EN
    output logic [7:0]        err_count,
`endif
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              error
);
    tl_state_e         st, st_n;
    logic [PTR_W:0]    af_q, ae_q, count;
    logic [DATA_W-1:0] rd_data;
    logic              live, run, ovf, udf, wr, rd, flush;

    // Events are still observed in ERROR (for the counter) but never move data there.
    always_comb begin
        live  = (st == ST_IDLE || st == ST_ACTIVE || st == ST_ERROR) && !init;
        run   = (st == ST_IDLE || st == ST_ACTIVE) && !init;
        udf   = live && pop && empty;
        ovf   = live && push && full && !pop;
        wr    = run && push && !udf && !ovf;
        rd    = run && pop && !empty;
        st_n  = st;
        case (st)
            ST_RESET:  st_n = ST_INIT;
            ST_INIT:   st_n = init ? ST_INIT : ST_IDLE;
            ST_IDLE:   st_n = init ? ST_INIT : udf ? ST_ERROR : wr ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE: st_n = init ? ST_INIT : (ovf || udf) ? ST_ERROR :
                              (rd && !wr && count == (PTR_W+1)'(1)) ? ST_IDLE : ST_ACTIVE;
            ST_ERROR:  st_n = init ? ST_INIT : ST_ERROR;
            default:   st_n = ST_RESET;
        endcase
        flush = st_n == ST_INIT;
    end

    assign state = st;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            st        <= ST_RESET;
            data_out  <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
            af_q      <= (PTR_W+1)'(DEPTH - 2);
            ae_q      <= (PTR_W+1)'(2);
        end else begin
            st        <= st_n;
            valid_out <= rd;
            error     <= flush ? 1'b0 : error | ovf | udf;
            if (rd) data_out <= rd_data;
            if (st == ST_INIT) begin
                af_q <= thr_af;
                ae_q <= thr_ae;
            end
        end
    end

`ifdef TL_FIFO_FSM_ERRCNT_EN
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) err_count <= '0;
        else if (flush) err_count <= '0;
        else if ((ovf || udf) && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
`endif

    tl_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk          (clk),
        .reset_L      (reset_L),
        .flush        (flush),
        .wr           (wr),
        .rd           (rd),
        .wr_data      (push_data),
        .thr_af       (af_q),
        .thr_ae       (ae_q),
        .rd_data      (rd_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );
endmodule
